// File: rtl/led_dec_pkg.sv
// Shared decoder codes and arbiter state encoding for the LED decoder arbiter.
package led_dec_pkg;

  localparam logic [2:0] DEC_EN_ON   = 3'd4;
  localparam logic [2:0] DEC_EN_OFF  = 3'd0;
  localparam logic [7:0] LED_ALL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_e;

endpackage

// File: rtl/led_decoder_3to8.sv
// Active-low 3-to-8 LED decoder; any enable code other than DEC_EN_ON blanks the bank.
module led_decoder_3to8
  import led_dec_pkg::*;
(
  input  logic [2:0] enable,
  input  logic [2:0] switch,
  output logic [7:0] led
);

  always_comb begin
    led = LED_ALL_OFF;
    if (enable == DEC_EN_ON) begin
      led = ~(8'b1 << switch);
    end
  end

endmodule

// File: rtl/led_decoder_arbiter.sv
// Round-robin arbiter sharing one active-low 3-to-8 LED decoder between N_REQ requesters.
module led_decoder_arbiter
  import led_dec_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   idx,
  output logic [N_REQ-1:0]     grant,
  output logic                 done,
  output logic [2:0]           dec_enable,
  output logic [2:0]           dec_switch,
  output logic [7:0]           led
);

  localparam int unsigned PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CMAX      = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW        = ($clog2(CMAX + 1) > 0) ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES >= 2) ? (GAP_CYCLES - 2) : 0);

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               done_q, done_d;
  logic [2:0]         en_q, en_d;
  logic [2:0]         sw_q, sw_d;

  logic [PW-1:0]      ptr_inc;
  logic [PW-1:0]      base;
  logic [PW-1:0]      win;
  logic               found;
  logic               take;
  logic               rel;

  assign ptr_inc = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

  // Search starts at the rr pointer in IDLE, or just past the owner when a
  // zero-gap release hands the decoder straight to the next requester.
  always_comb begin
    int unsigned cand;
    base  = (state_q == IDLE) ? ptr_q : ptr_inc;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = int'(base) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  // The blanking IDLE cycle counts as one gap clock, so GAP holds for GAP_CYCLES-1.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    en_d    = en_q;
    sw_d    = sw_q;
    take    = 1'b0;
    rel     = 1'b0;

    case (state_q)
      IDLE: take = found;
      ACTIVE: begin
        if (!req[owner_q] || (cnt_q == '0)) begin
          rel = 1'b1;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          done_d = (cnt_q == CW'(1));
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      grant_d = '0;
      en_d    = DEC_EN_OFF;
      ptr_d   = ptr_inc;
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
        take    = found;
      end else if (GAP_CYCLES == 1) begin
        state_d = IDLE;
      end else begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
      end
    end

    if (take) begin
      state_d = ACTIVE;
      owner_d = win;
      grant_d = N_REQ'(1) << win;
      en_d    = DEC_EN_ON;
      sw_d    = idx[3*int'(win) +: 3];
      cnt_d   = HOLD_LOAD;
      done_d  = (HOLD_CYCLES == 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      en_q    <= DEC_EN_OFF;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      en_q    <= en_d;
      sw_q    <= sw_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign dec_enable = en_q;
  assign dec_switch = sw_q;

  led_decoder_3to8 u_dec (
    .enable (en_q),
    .switch (sw_q),
    .led    (led)
  );

endmodule

// File: tb/tb_led_decoder_arbiter.sv
// Directed bench for led_decoder_arbiter with N_REQ=4, HOLD_CYCLES=4, GAP_CYCLES=1.
module tb_led_decoder_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] idx = '0;
  logic [3:0]  grant;
  logic        done;
  logic [2:0]  dec_enable;
  logic [2:0]  dec_switch;
  logic [7:0]  led;

  int unsigned checks = 0;
  int unsigned errors = 0;

  led_decoder_arbiter #(
    .N_REQ       (4),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .idx        (idx),
    .grant      (grant),
    .done       (done),
    .dec_enable (dec_enable),
    .dec_switch (dec_switch),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input logic [3:0] g, input logic [7:0] l, input logic d);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_led"},   32'(led),   32'(l));
    check({tag, "_done"},  32'(done),  32'(d));
  endtask

  task automatic dark(input string tag);
    lit(tag, 4'b0000, 8'hFF, 1'b0);
    check({tag, "_en"}, 32'(dec_enable), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [3:0] rr_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_led   [5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFE};

  initial begin
    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dark("rst_hold");
    rst = 1'b1;
    step();
    dark("rst_rel0");
    step();
    dark("rst_rel1");

    // single request: 4 lit cycles, done on the 4th, 1 dark, then re-grant
    idx = 12'(5);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      lit($sformatf("single_c%0d", c), 4'b0001, 8'hDF, c == 3);
      check($sformatf("single_en_c%0d", c), 32'(dec_enable), 32'd4);
    end
    step();
    dark("single_gap");
    step();
    lit("single_regrant", 4'b0001, 8'hDF, 1'b0);

    // round robin
    do_reset();
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        lit($sformatf("rr%0d_c%0d", g, c), rr_grant[g], rr_led[g], c == 3);
      end
      step();
      dark($sformatf("rr%0d_gap", g));
    end

    // abort in 2nd lit cycle, then pointer has moved past 1
    do_reset();
    idx = {3'd0, 3'd0, 3'd7, 3'd0};
    req = 4'b0010;
    step();
    lit("abort_c0", 4'b0010, 8'h7F, 1'b0);
    step();
    lit("abort_c1", 4'b0010, 8'h7F, 1'b0);
    req = 4'b0000;
    step();
    dark("abort_off");
    req = 4'b0011;
    step();
    lit("abort_next", 4'b0001, 8'hFE, 1'b0);

    // latched index survives an idx change mid-grant
    do_reset();
    idx = 12'(2);
    req = 4'b0001;
    step();
    lit("latch_c0", 4'b0001, 8'hFB, 1'b0);
    idx = 12'(6);
    for (int c = 1; c < 4; c++) begin
      step();
      lit($sformatf("latch_c%0d", c), 4'b0001, 8'hFB, c == 3);
    end

    // async reset mid-grant after the pointer has advanced to 1
    do_reset();
    idx = {3'd0, 3'd0, 3'd1, 3'd3};
    req = 4'b0001;
    repeat (5) step();
    req = 4'b0010;
    step();
    lit("arst_pre", 4'b0010, 8'hFD, 1'b0);
    step();
    #2;
    rst = 1'b0;
    #1;
    dark("arst_now");
    req = 4'b0011;
    step();
    dark("arst_held");
    rst = 1'b1;
    step();
    lit("arst_ptr0", 4'b0001, 8'hF7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
